// File: rtl/div3_pkg.sv
// Shared types and constants for the divide-by-3 result checker.
// Anything that must agree with the divider datapath lives here.
package div3_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  localparam int DIV3_DIVISOR = 3;
  localparam int REM_W        = 2;

  // Reconstruction width: quotient*3 + remainder never exceeds SIZE+2 bits.
  function automatic int recon_w(input int size);
    return size + 2;
  endfunction

endpackage

// File: rtl/div3_align_delay.sv
// {valid, data} shift pipeline that lines the divider input tap up with its output.
// flush_i clears only the valid bits; data is don't-care while invalid.
module div3_align_delay #(
  parameter int W     = 20,
  parameter int DEPTH = 3
) (
  input  logic         clk_i,
  input  logic         flush_i,
  input  logic         vld_i,
  input  logic [W-1:0] data_i,
  output logic         vld_o,
  output logic [W-1:0] data_o
);

  logic [DEPTH-1:0]         vld_q;
  logic [DEPTH-1:0][W-1:0]  data_q;

  always_ff @(posedge clk_i) begin
    if (flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= vld_i;
      for (int i = 1; i < DEPTH; i++) vld_q[i] <= vld_q[i-1];
    end
    data_q[0] <= data_i;
    for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
  end

  assign vld_o  = vld_q[DEPTH-1];
  assign data_o = data_q[DEPTH-1];

endmodule

// File: rtl/div3_result_checker.sv
// Checks quotient*3 + remainder == dividend for a run of NUM_SAMPLES samples,
// keeping pass/error counts and a sticky capture of the first failure.
module div3_result_checker
  import div3_pkg::*;
#(
  parameter int SIZE        = 20,
  parameter int LATENCY     = 3,
  parameter int NUM_SAMPLES = 1024,
  parameter int CNT_W       = 16
) (
  input  logic             sys_clock,
  input  logic             reset,
  input  logic             start,
  input  logic             in_valid,
  input  logic [SIZE-1:0]  divident,
  input  logic [SIZE-1:0]  quotient,
  input  logic [REM_W-1:0] reminder,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [SIZE-1:0]  first_err_divident,
  output logic [SIZE-1:0]  first_err_quotient,
  output logic [REM_W-1:0] first_err_reminder
);

  localparam int               RW  = recon_w(SIZE);
  localparam logic [CNT_W-1:0] NUM = CNT_W'(NUM_SAMPLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   issued_q, issued_d, checked_q, checked_d;
  logic [CNT_W-1:0]   pass_q, pass_d, err_q, err_d;
  logic               fev_q, fev_d;
  logic [SIZE-1:0]    fed_q, fed_d, feq_q, feq_d;
  logic [REM_W-1:0]   fer_q, fer_d;

  logic               chk_vld_q, chk_good_q;
  logic [SIZE-1:0]    chk_div_q, chk_quo_q;
  logic [REM_W-1:0]   chk_rem_q;

  logic               start_ok, accept, dl_vld, good;
  logic [SIZE-1:0]    dl_div;
  logic [RW-1:0]      recon;

  assign start_ok = start && (state_q == IDLE || state_q == DONE);
  assign accept   = in_valid && (state_q == RUN) && (issued_q < NUM);

  div3_align_delay #(.W(SIZE), .DEPTH(LATENCY)) u_align (
    .clk_i   (sys_clock),
    .flush_i (reset || start_ok),
    .vld_i   (accept),
    .data_i  (divident),
    .vld_o   (dl_vld),
    .data_o  (dl_div)
  );

  assign recon = RW'(quotient) * RW'(DIV3_DIVISOR) + RW'(reminder);
  assign good  = (recon == RW'(dl_div)) && (reminder != REM_W'(DIV3_DIVISOR));

  // FSM: state register
  always_ff @(posedge sys_clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)             state_d = RUN;
      RUN:     if (issued_q == NUM)   state_d = DRAIN;
      DRAIN:   if (checked_q == NUM)  state_d = DONE;
      DONE:    if (start)             state_d = RUN;
      default:                        state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == RUN) || (state_q == DRAIN);
    done = (state_q == DONE);
  end

  always_comb begin
    issued_d  = issued_q;
    checked_d = checked_q;
    pass_d    = pass_q;
    err_d     = err_q;
    fev_d     = fev_q;
    fed_d     = fed_q;
    feq_d     = feq_q;
    fer_d     = fer_q;
    if (start_ok) begin
      issued_d  = '0;
      checked_d = '0;
      pass_d    = '0;
      err_d     = '0;
      fev_d     = 1'b0;
      fed_d     = '0;
      feq_d     = '0;
      fer_d     = '0;
    end else begin
      if (accept) issued_d = sat_inc(issued_q);
      if (chk_vld_q) begin
        checked_d = sat_inc(checked_q);
        if (chk_good_q) begin
          pass_d = sat_inc(pass_q);
        end else begin
          err_d = sat_inc(err_q);
          if (!fev_q) begin
            fev_d = 1'b1;
            fed_d = chk_div_q;
            feq_d = chk_quo_q;
            fer_d = chk_rem_q;
          end
        end
      end
    end
  end

  always_ff @(posedge sys_clock) begin
    if (reset) begin
      issued_q   <= '0;
      checked_q  <= '0;
      pass_q     <= '0;
      err_q      <= '0;
      fev_q      <= 1'b0;
      fed_q      <= '0;
      feq_q      <= '0;
      fer_q      <= '0;
      chk_vld_q  <= 1'b0;
      chk_good_q <= 1'b0;
      chk_div_q  <= '0;
      chk_quo_q  <= '0;
      chk_rem_q  <= '0;
    end else begin
      issued_q   <= issued_d;
      checked_q  <= checked_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fev_q      <= fev_d;
      fed_q      <= fed_d;
      feq_q      <= feq_d;
      fer_q      <= fer_d;
      chk_vld_q  <= dl_vld && !start_ok;
      chk_good_q <= good;
      chk_div_q  <= dl_div;
      chk_quo_q  <= quotient;
      chk_rem_q  <= reminder;
    end
  end

  assign pass_count         = pass_q;
  assign err_count          = err_q;
  assign first_err_valid    = fev_q;
  assign first_err_divident = fed_q;
  assign first_err_quotient = feq_q;
  assign first_err_reminder = fer_q;

endmodule

// File: tb/tb_div3_result_checker.sv
// Randomized bench for div3_result_checker: a divider-response scheduler plus a
// sample-list model that predicts counts and the first-error capture.
module tb_div3_result_checker;

  localparam int SZ = 20;
  localparam int L  = 3;
  localparam int NS = 10;
  localparam int CW = 16;

  logic          sys_clock = 1'b0;
  logic          reset, start, in_valid;
  logic [SZ-1:0] divident, quotient;
  logic [1:0]    reminder;
  logic          busy, done, first_err_valid;
  logic [CW-1:0] pass_count, err_count;
  logic [SZ-1:0] first_err_divident, first_err_quotient;
  logic [1:0]    first_err_reminder;

  div3_result_checker #(.SIZE(SZ), .LATENCY(L), .NUM_SAMPLES(NS), .CNT_W(CW)) dut (
    .sys_clock          (sys_clock),
    .reset              (reset),
    .start              (start),
    .in_valid           (in_valid),
    .divident           (divident),
    .quotient           (quotient),
    .reminder           (reminder),
    .busy               (busy),
    .done               (done),
    .pass_count         (pass_count),
    .err_count          (err_count),
    .first_err_valid    (first_err_valid),
    .first_err_divident (first_err_divident),
    .first_err_quotient (first_err_quotient),
    .first_err_reminder (first_err_reminder)
  );

  always #5 sys_clock = ~sys_clock;

  int n_chk = 0, n_fail = 0, cyc = 0;

  // divider responses scheduled L cycles after the dividend is presented
  logic [SZ-1:0] rq [16];
  logic [1:0]    rr [16];

  // sample list for a run
  logic [SZ-1:0] sd [16];
  logic [SZ-1:0] sq [16];
  logic [1:0]    sr [16];

  // model
  bit            m_running, m_busy, m_fev;
  int            m_issued, m_pass, m_err;
  logic [SZ-1:0] m_fed, m_feq;
  logic [1:0]    m_fer;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_issued = 0; m_pass = 0; m_err = 0; m_fev = 0;
    m_fed = '0; m_feq = '0; m_fer = '0;
  endtask

  task automatic step(input logic s, input logic v, input logic [SZ-1:0] d,
                      input logic [SZ-1:0] q, input logic [1:0] r);
    longint recon;
    start = s; in_valid = v; divident = d;
    quotient = rq[cyc % 16]; reminder = rr[cyc % 16];
    rq[(cyc + L) % 16] = q; rr[(cyc + L) % 16] = r;
    if (v && m_running && m_issued < NS) begin
      m_issued++;
      recon = longint'(q) * 3 + longint'(r);
      if (recon == longint'(d) && r != 2'd3) m_pass++;
      else begin
        m_err++;
        if (!m_fev) begin m_fev = 1; m_fed = d; m_feq = q; m_fer = r; end
      end
    end
    if (s && !m_busy) begin model_clear(); m_busy = 1; m_running = 1; end
    @(posedge sys_clock); #1; cyc++;
  endtask

  task automatic idle();
    step(0, 0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    reset = 1'b0;
    model_clear(); m_running = 0; m_busy = 0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && !done; k++) idle();
    chk("done_wait", done, 1);
    m_busy = 0;
  endtask

  task automatic check_counts(input string tag);
    chk({tag, "_pass"}, pass_count, m_pass);
    chk({tag, "_err"},  err_count,  m_err);
    chk({tag, "_fev"},  first_err_valid, m_fev);
    if (m_fev) begin
      chk({tag, "_fed"}, first_err_divident, m_fed);
      chk({tag, "_feq"}, first_err_quotient, m_feq);
      chk({tag, "_fer"}, first_err_reminder, m_fer);
    end
  endtask

  task automatic set_good(input int i, input logic [SZ-1:0] d);
    sd[i] = d; sq[i] = d / 3; sr[i] = 2'(d % 3);
  endtask

  task automatic set_rand(input int i);
    set_good(i, SZ'($urandom_range(0, (1 << SZ) - 1)));
    case ($urandom % 5)
      0: sq[i] = sq[i] + 1'b1;
      1: sr[i] = 2'd3;
      default: ;
    endcase
  endtask

  task automatic do_run(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom % 4 == 0) idle();
      step(0, 1, sd[i], sq[i], sr[i]);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin rq[i] = '0; rr[i] = '0; end
    start = 0; in_valid = 0; divident = '0; quotient = '0; reminder = '0;
    m_running = 0; m_busy = 0; model_clear();
    reset = 1'b1;
    idle(); idle();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass_count, 0);
    chk("rst_err",  err_count, 0);
    chk("rst_fev",  first_err_valid, 0);
    chk("rst_fed",  first_err_divident, 0);

    // 1: clean 0..9, done timing
    step(1, 0, '0, '0, '0);
    chk("t1_busy", busy, 1);
    for (int i = 0; i < NS; i++) step(0, 1, SZ'(i), SZ'(i / 3), 2'(i % 3));
    for (int k = 1; k <= L + 2; k++) begin
      idle();
      if (k == L + 1) chk("t1_done_early", done, 0);
    end
    chk("t1_done_lat", done, 1);
    chk("t1_busy_end", busy, 0);
    wait_done();
    check_counts("t1");

    // 2: first error captured, second does not overwrite
    for (int i = 0; i < NS; i++) set_good(i, SZ'($urandom_range(0, 200000)));
    sd[3] = 7; sq[3] = 2; sr[3] = 0;
    sd[6] = 8; sq[6] = 1; sr[6] = 1;
    step(1, 0, '0, '0, '0);
    do_run(NS);
    wait_done();
    check_counts("t2");
    chk("t2_err2", err_count, 2);

    // 3: recon matches but remainder 3 is illegal
    for (int i = 0; i < NS; i++) set_good(i, SZ'($urandom_range(0, 1000)));
    sd[5] = 3; sq[5] = 0; sr[5] = 3;
    step(1, 0, '0, '0, '0);
    do_run(NS);
    wait_done();
    check_counts("t3");

    // 4: max dividend, no recon overflow
    for (int i = 0; i < NS; i++) set_good(i, SZ'($urandom_range(0, (1 << SZ) - 1)));
    sd[2] = 20'hFFFFF; sq[2] = 20'd349525; sr[2] = 0;
    sd[7] = 20'hFFFFF; sq[7] = 20'd349524; sr[7] = 3;
    step(1, 0, '0, '0, '0);
    do_run(NS);
    wait_done();
    check_counts("t4");

    // 5: reset mid-run discards everything in flight
    step(1, 0, '0, '0, '0);
    step(0, 1, 20'd9, 20'd2, 2'd0);
    for (int i = 1; i < 4; i++) step(0, 1, SZ'(30 + i), SZ'(10), 2'(i % 3));
    idle();
    chk("t5_pre_err", err_count, 1);
    chk("t5_pre_fev", first_err_valid, 1);
    do_reset();
    chk("t5_busy", busy, 0);
    check_counts("t5_rst");
    for (int k = 0; k < 6; k++) idle();
    check_counts("t5_late");
    chk("t5_idle", busy, 0);

    // 6: start ignored in RUN; extra valids dropped; restart from DONE
    step(1, 0, '0, '0, '0);
    for (int i = 0; i < 15; i++) begin
      set_rand(0);
      step(i == 2, 1, sd[0], sq[0], sr[0]);
    end
    wait_done();
    check_counts("t6a");
    chk("t6a_total", 64'(pass_count) + 64'(err_count), NS);
    step(1, 0, '0, '0, '0);
    check_counts("t6_clr");
    chk("t6_busy", busy, 1);
    for (int i = 0; i < NS; i++) set_rand(i);
    do_run(NS);
    wait_done();
    check_counts("t6b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
